// File: rtl/vit_ctrl.sv
// vit_ctrl -- Viterbi decoder frame controller.
// Sequences one frame through repeated trellis blocks: FILL accepts symbols
// into the trellis memory and runs add-compare-select, TRACE reads the
// memory back for traceback, and GAP (one cycle) returns the memory to
// write mode before the next block or the end of the frame.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous active-low reset
//   i_start     frame start request (sampled only in IDLE)
//   i_abort     synchronous frame abort, highest priority
//   i_sym_vld   received symbol valid
//   i_sym_last  final symbol of frame (qualified by i_sym_vld)
//   o_sym_rdy   symbol accepted this cycle when i_sym_vld is high
//   i_td_full   trellis memory full flag
//   i_td_empty  trellis memory empty flag
//   o_en_td     trellis memory enable
//   o_ood       out-of-data marker (last-symbol accept)
//   o_en_acs    add-compare-select enable
//   o_en_tb     traceback enable
//   o_busy      controller not idle
//   o_done      frame-complete pulse
//   o_err       sticky protocol error
//   o_blk_cnt   symbols accepted in the current block
module vit_ctrl #(
   parameter int unsigned TB_DEPTH = 64,
   parameter int unsigned CNT_W    = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic             i_abort,
   input  logic             i_sym_vld,
   input  logic             i_sym_last,
   output logic             o_sym_rdy,
   input  logic             i_td_full,
   input  logic             i_td_empty,
   output logic             o_en_td,
   output logic             o_ood,
   output logic             o_en_acs,
   output logic             o_en_tb,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err,
   output logic [CNT_W-1:0] o_blk_cnt
);

   typedef enum logic [1:0] {IDLE, FILL, TRACE, GAP} state_t;

   localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(TB_DEPTH);
   localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(TB_DEPTH - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] timer, timer_nxt;
   logic             err, err_nxt;
   logic             ended, ended_nxt;   // frame finishes after this block
   logic             quiet, quiet_nxt;   // suppress o_done (abort / timeout)
   logic             accept;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         timer <= '0;
         err   <= 1'b0;
         ended <= 1'b0;
         quiet <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         timer <= timer_nxt;
         err   <= err_nxt;
         ended <= ended_nxt;
         quiet <= quiet_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      timer_nxt = timer;
      err_nxt   = err;
      ended_nxt = ended;
      quiet_nxt = quiet;
      accept    = 1'b0;
      o_sym_rdy = 1'b0;
      o_en_td   = 1'b0;
      o_ood     = 1'b0;
      o_en_acs  = 1'b0;
      o_en_tb   = 1'b0;
      o_done    = 1'b0;

      case (state)
         IDLE: begin
            if (i_start && !i_abort) begin
               state_nxt = FILL;
               cnt_nxt   = '0;
               err_nxt   = 1'b0;
               ended_nxt = 1'b0;
               quiet_nxt = 1'b0;
            end
         end

         FILL: begin
            o_sym_rdy = 1'b1;
            accept    = i_sym_vld;
            o_en_td   = accept;
            o_en_acs  = accept;
            o_ood     = accept & i_sym_last;
            if (i_td_empty && (cnt != '0))
               err_nxt = 1'b1;
            if (accept) begin
               if (i_sym_last) begin
                  // last wins over full: the frame ends after this trace
                  ended_nxt = 1'b1;
                  state_nxt = TRACE;
                  timer_nxt = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
                  if (i_td_full) begin
                     state_nxt = TRACE;
                     timer_nxt = '0;
                  end else if (cnt == DEPTH_M1) begin
                     // block is at full depth but memory never said so
                     err_nxt   = 1'b1;
                     state_nxt = TRACE;
                     timer_nxt = '0;
                  end
               end
            end
         end

         TRACE: begin
            o_en_td   = 1'b1;
            o_en_tb   = 1'b1;
            timer_nxt = timer + 1'b1;
            if (i_td_empty) begin
               state_nxt = GAP;
            end else if (timer == DEPTH) begin
               err_nxt   = 1'b1;
               ended_nxt = 1'b1;
               quiet_nxt = 1'b1;
               state_nxt = GAP;
            end
         end

         GAP: begin
            o_done  = ended & ~quiet & ~i_abort;
            cnt_nxt = '0;   // cleared on the way out so IDLE shows zero
            if (ended) begin
               state_nxt = IDLE;
               ended_nxt = 1'b0;
               quiet_nxt = 1'b0;
            end else begin
               state_nxt = FILL;
            end
         end

         default: state_nxt = IDLE;
      endcase

      if (i_abort && (state != IDLE)) begin
         state_nxt = GAP;
         ended_nxt = 1'b1;
         quiet_nxt = 1'b1;
      end
   end

   assign o_busy    = (state != IDLE);
   assign o_err     = err;
   assign o_blk_cnt = cnt;

endmodule

// File: tb/tb_vit_ctrl.sv
module tb_vit_ctrl;
   localparam int unsigned DEPTH = 64;
   localparam int unsigned CW    = 7;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          i_start = 1'b0, i_abort = 1'b0;
   logic          i_sym_vld = 1'b0, i_sym_last = 1'b0;
   logic          i_td_full = 1'b0, i_td_empty = 1'b0;
   logic          o_sym_rdy, o_en_td, o_ood, o_en_acs, o_en_tb;
   logic          o_busy, o_done, o_err;
   logic [CW-1:0] o_blk_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   bit exp_err = 1'b0;

   vit_ctrl #(.TB_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
      .i_sym_vld(i_sym_vld), .i_sym_last(i_sym_last), .o_sym_rdy(o_sym_rdy),
      .i_td_full(i_td_full), .i_td_empty(i_td_empty), .o_en_td(o_en_td),
      .o_ood(o_ood), .o_en_acs(o_en_acs), .o_en_tb(o_en_tb), .o_busy(o_busy),
      .o_done(o_done), .o_err(o_err), .o_blk_cnt(o_blk_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      n_tests++;
      assert (obs === want) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
      end
   endtask

   task automatic chk_all(input string tag, input bit rdy, input bit en_td, input bit ood,
                          input bit acs, input bit tb, input bit busy, input bit done,
                          input int cnt);
      chk({tag, ".rdy"},  32'(o_sym_rdy), 32'(rdy));
      chk({tag, ".en_td"}, 32'(o_en_td), 32'(en_td));
      chk({tag, ".ood"},  32'(o_ood),    32'(ood));
      chk({tag, ".acs"},  32'(o_en_acs), 32'(acs));
      chk({tag, ".tb"},   32'(o_en_tb),  32'(tb));
      chk({tag, ".busy"}, 32'(o_busy),   32'(busy));
      chk({tag, ".done"}, 32'(o_done),   32'(done));
      chk({tag, ".err"},  32'(o_err),    32'(exp_err));
      chk({tag, ".cnt"},  32'(o_blk_cnt), 32'(cnt));
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      i_start = 1'b1;
      #3 chk_all("idle_start", 0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
      i_start = 1'b0;
      exp_err = 1'b0;
   endtask

   // Whole frame of `total` symbols; blocks end on the DEPTH-th accept
   // (full flag if full_works, otherwise flagged error) or on the last symbol.
   task automatic run_frame(input int total, input bit rand_vld, input bit full_works);
      int sent, blk, guard, len;
      bit v, is_last, is_full, ended, timeout;
      sent = 0; ended = 1'b0; timeout = 1'b0;
      is_last = 1'b0; is_full = 1'b0;
      do_start();
      while (!ended && !timeout) begin
         blk = 0; guard = 0;
         forever begin
            v       = rand_vld ? 1'($urandom_range(0, 1)) : 1'b1;
            is_last = v && (sent + 1 == total);
            is_full = v && full_works && (blk + 1 == int'(DEPTH));
            i_sym_vld  = v;
            i_sym_last = v ? is_last : 1'($urandom_range(0, 1));
            i_td_full  = is_full;
            #3 chk_all("fill", 1, v, is_last, v, 0, 1, 0, blk);
            next_cycle();
            guard++;
            if (v) begin
               sent++;
               if (!is_last) blk++;
            end
            if (v && !is_last && !is_full && blk == int'(DEPTH)) exp_err = 1'b1;
            if (v && (is_last || is_full || blk == int'(DEPTH))) break;
            if (guard > 4000) begin
               chk("fill_budget", 32'd0, 32'd1);
               i_sym_vld = 1'b0;
               return;
            end
         end
         ended = is_last;
         i_sym_vld = 1'b0; i_sym_last = 1'b0; i_td_full = 1'b0;
         len = full_works ? int'($urandom_range(1, DEPTH + 1)) : 0;
         for (int c = 1; c <= int'(DEPTH) + 1; c++) begin
            i_td_empty = (c == len);
            #3 chk_all("trace", 0, 1, 0, 0, 1, 1, 0, blk);
            next_cycle();
            if (c == len) break;
         end
         i_td_empty = 1'b0;
         if (len == 0) begin
            timeout = 1'b1;
            exp_err = 1'b1;
         end
         #3 chk_all("gap", 0, 0, 0, 0, 0, 1, ended && !timeout, blk);
         next_cycle();
      end
      #3 chk_all("idle_end", 0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();
   endtask

   initial begin
      // reset state
      #12 chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk) rst = 1'b1;
      next_cycle();
      chk_all("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();

      run_frame(10, 1'b1, 1'b1);    // short frame, last on 10th
      run_frame(150, 1'b0, 1'b1);   // continuous: 64 + 64 + 22
      run_frame(150, 1'b1, 1'b1);   // same with gappy valid
      run_frame(64, 1'b1, 1'b1);    // full and last on the same accept
      for (int k = 0; k < 4; k++)
         run_frame(int'($urandom_range(1, 200)), 1'b1, 1'b1);
      run_frame(100, 1'b0, 1'b0);   // full stuck low, empty never

      // empty in FILL, then abort mid-FILL (also clears the prior error)
      do_start();
      i_td_empty = 1'b1;
      #3 chk_all("empty_cnt0", 1, 0, 0, 0, 0, 1, 0, 0);
      next_cycle();
      i_td_empty = 1'b0;
      for (int k = 0; k < 3; k++) begin
         i_sym_vld = 1'b1;
         #3 chk_all("pre_empty", 1, 1, 0, 1, 0, 1, 0, k);
         next_cycle();
      end
      i_sym_vld = 1'b0;
      i_td_empty = 1'b1;
      #3 chk_all("empty_cnt3", 1, 0, 0, 0, 0, 1, 0, 3);
      next_cycle();
      i_td_empty = 1'b0;
      exp_err = 1'b1;
      i_abort = 1'b1;
      #3 chk_all("abort", 1, 0, 0, 0, 0, 1, 0, 3);
      next_cycle();
      i_abort = 1'b0;
      #3 chk_all("abort_gap", 0, 0, 0, 0, 0, 1, 0, 3);
      next_cycle();
      #3 chk_all("abort_idle", 0, 0, 0, 0, 0, 0, 0, 0);
      next_cycle();

      // reset mid-TRACE
      do_start();
      for (int k = 0; k < 5; k++) begin
         i_sym_vld  = 1'b1;
         i_sym_last = (k == 4);
         #3 chk_all("rfill", 1, 1, (k == 4), 1, 0, 1, 0, k);
         next_cycle();
      end
      i_sym_vld = 1'b0; i_sym_last = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #3 chk_all("rtrace", 0, 1, 0, 0, 1, 1, 0, 4);
         next_cycle();
      end
      rst = 1'b0;
      exp_err = 1'b0;
      #1 chk_all("rst_trace", 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk) rst = 1'b1;
      next_cycle();
      for (int k = 0; k < 3; k++) begin
         #3 chk_all("rst_exit", 0, 0, 0, 0, 0, 0, 0, 0);
         next_cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/vit_ctrl.md
VIT_CTRL -- requirements
Module: vit_ctrl

Interface
REQ-001 SHALL have parameter TB_DEPTH, default 64, meaning trellis traceback depth in symbols (matches trellis memory depth).
REQ-002 SHALL have parameter CNT_W, default 7, meaning width of depth and symbol counters (2**CNT_W >= TB_DEPTH+1).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_start  input  1  frame start request, sampled only in IDLE.
REQ-006 SHALL have port i_abort  input  1  synchronous frame abort, any state.
REQ-007 SHALL have port i_sym_vld  input  1  received symbol valid.
REQ-008 SHALL have port i_sym_last  input  1  qualifies i_sym_vld: final symbol of frame.
REQ-009 SHALL have port o_sym_rdy  output  1  controller accepts a symbol this cycle.
REQ-010 SHALL have port i_td_full  input  1  trellis memory full flag.
REQ-011 SHALL have port i_td_empty  input  1  trellis memory empty flag.
REQ-012 SHALL have port o_en_td  output  1  trellis memory enable.
REQ-013 SHALL have port o_ood  output  1  out-of-data marker to trellis memory.
REQ-014 SHALL have port o_en_acs  output  1  add-compare-select enable.
REQ-015 SHALL have port o_en_tb  output  1  traceback enable.
REQ-016 SHALL have ports o_busy (1, not IDLE), o_done (1, frame-complete pulse), o_err (1, sticky protocol error), o_blk_cnt (CNT_W, symbols accepted in current block), all outputs.

Function
REQ-017 SHALL implement FSM states IDLE, FILL, TRACE, GAP; encoding free.
REQ-018 SHALL transition IDLE->FILL on i_start=1 and i_abort=0; i_start ignored outside IDLE.
REQ-019 SHALL, in FILL, drive o_sym_rdy=1; accept = i_sym_vld & o_sym_rdy; o_en_td=o_en_acs=accept (combinational, same cycle).
REQ-020 SHALL increment o_blk_cnt on each accept except a last-symbol accept; counter clears on entry to FILL.
REQ-021 SHALL drive o_ood=1 only on the accept cycle with i_sym_last=1; otherwise 0.
REQ-022 SHALL go FILL->TRACE on an accept with i_td_full=1 or i_sym_last=1; both together treated as last (frame ends after trace).
REQ-023 SHALL, in TRACE, hold o_en_td=1 and o_en_tb=1 every cycle without gaps, o_sym_rdy=0, o_en_acs=0.
REQ-024 SHALL go TRACE->GAP on the cycle i_td_empty=1 (that read at depth 0 still performed with enables high).
REQ-025 SHALL, in GAP (exactly 1 cycle), drive o_en_td=0 so trellis mode returns to write; o_done=1 if frame ended, then ->IDLE; else ->FILL with o_done=0.
REQ-026 SHALL set o_err=1 if an accept in FILL makes o_blk_cnt reach TB_DEPTH while i_td_full=0 (flag/counter mismatch), and then force ->TRACE; o_err clears only on reset or i_start in IDLE.
REQ-027 SHALL set o_err=1 if i_td_empty=1 in FILL while o_blk_cnt>0.
REQ-028 SHALL treat TRACE lasting more than TB_DEPTH+1 cycles as error: o_err=1, ->GAP, o_done=0, ->IDLE.
REQ-029 SHALL, on i_abort=1, go ->GAP next edge with frame marked ended and o_done suppressed, then IDLE; i_abort has priority over all transitions.
REQ-030 SHALL drive o_busy=1 in all states except IDLE.

Reset
REQ-031 SHALL on rst=0 immediately force state IDLE, o_blk_cnt=0, o_err=0, trace timer=0, frame-ended flag=0.
REQ-032 SHALL hold all outputs 0 during reset and in IDLE, mid-frame reset included; no o_done pulse on reset exit.

Verification
REQ-033 SHALL cover: start, 10 symbols with last on 10th -> o_ood one cycle, TRACE until i_td_empty, GAP with o_done=1, IDLE; o_blk_cnt=9.
REQ-034 SHALL cover: 150 continuous symbols, TB_DEPTH=64, full on 64th -> two FILL/TRACE/GAP cycles without o_done, third block ends by last, one o_done.
REQ-035 SHALL cover: i_sym_vld toggling 1/0 in FILL -> o_en_td/o_en_acs mirror accepts; o_blk_cnt counts only accepts.
REQ-036 SHALL cover: i_td_full and i_sym_last same accept -> o_ood=1, single TRACE, o_done=1.
REQ-037 SHALL cover: i_td_full stuck 0 -> o_err=1 at 64th accept, forced TRACE; i_td_empty never -> timeout after 65 cycles, IDLE, o_done=0.
REQ-038 SHALL cover: rst=0 mid-TRACE and i_abort mid-FILL -> outputs 0 immediately / GAP then IDLE, no o_done.
